// File: rtl/atm_room_access_ctrl.sv
// ATM secure-room access controller: keypad passcode stream, entry timeout, tailgate detection.
// Define ATM_ROOM_LOCKOUT_EN to build the lockout after MAX_TRIES consecutive bad codes.
module atm_room_access_ctrl #(
   parameter int                          DIGITS         = 2,
   parameter int                          DIGIT_W        = 2,
   parameter logic [DIGITS*DIGIT_W-1:0]   PASSCODE       = 4'b0110,
   parameter int                          ENTRY_TIMEOUT  = 32,
   parameter int                          BLINK_DIV      = 2,
   parameter int                          MAX_TRIES      = 3,
   parameter int                          LOCKOUT_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             sensor_entry,
   input  logic                             sensor_exit,
   input  logic                             digit_valid,
   input  logic [DIGIT_W-1:0]               digit_in,
   output logic                             digit_ready,
   output logic                             green_light,
   output logic                             red_light,
   output logic [6:0]                       display_1,
   output logic [6:0]                       display_2,
   output logic [2:0]                       state_o,
   output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

   localparam int CODE_W    = DIGITS * DIGIT_W;
   localparam int BUF_W     = (DIGITS > 1) ? (DIGITS - 1) * DIGIT_W : DIGIT_W;
   localparam int DCNT_W    = (DIGITS > 1) ? $clog2(DIGITS + 1) : 1;
   localparam int PHASE_MAX = (ENTRY_TIMEOUT > LOCKOUT_CYCLES) ? ENTRY_TIMEOUT : LOCKOUT_CYCLES;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
   localparam int BLINK_W   = $clog2(BLINK_DIV + 1);
   localparam int FAIL_W    = $clog2(MAX_TRIES + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_CODE = 3'd1,
      S_BAD_CODE  = 3'd2,
      S_GRANTED   = 3'd3,
      S_TAILGATE  = 3'd4,
      S_LOCKOUT   = 3'd5
   } state_t;

   state_t               state_reg, state_next, bad_dest;
   logic [BUF_W-1:0]     buf_reg;
   logic [DCNT_W-1:0]    dcnt_reg;
   logic [PHASE_W-1:0]   phase_reg;
   logic                 phase_run;
   logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
   logic                 blink_reg, blink_next;
   logic [FAIL_W-1:0]    fail_reg, fail_next, fail_inc;
   logic                 ready_reg, ready_next;
   logic                 red_reg, red_next, green_reg, green_next;
   logic [6:0]           disp1_reg, disp1_next, disp2_reg, disp2_next;
   logic                 accept, code_done, code_match, state_change;
   logic [CODE_W-1:0]    code_word;

   // The last digit is compared together with the buffered ones in the cycle it arrives.
   generate
      if (DIGITS > 1) begin : g_multi_digit
         assign code_word = {buf_reg, digit_in};
      end else begin : g_single_digit
         assign code_word = digit_in;
      end
   endgenerate

   assign accept       = digit_valid && ready_reg;
   assign code_done    = accept && (dcnt_reg == DCNT_W'(DIGITS - 1));
   assign code_match   = (code_word == PASSCODE);
   assign state_change = (state_next != state_reg);
   assign fail_inc     = (fail_reg == FAIL_W'(MAX_TRIES)) ? fail_reg : fail_reg + 1'b1;

`ifdef ATM_ROOM_LOCKOUT_EN
   assign bad_dest  = (fail_inc == FAIL_W'(MAX_TRIES)) ? S_LOCKOUT : S_BAD_CODE;
   assign phase_run = (state_reg == S_WAIT_CODE) || (state_reg == S_LOCKOUT);
`else
   assign bad_dest  = S_BAD_CODE;
   assign phase_run = (state_reg == S_WAIT_CODE);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (sensor_entry) state_next = S_WAIT_CODE;
         end
         S_WAIT_CODE, S_BAD_CODE: begin
            // A code finishing on the timeout cycle wins over the timeout.
            if (code_done) begin
               state_next = code_match ? S_GRANTED : bad_dest;
            end else if ((state_reg == S_WAIT_CODE) &&
                         (phase_reg == PHASE_W'(ENTRY_TIMEOUT - 1))) begin
               state_next = S_IDLE;
            end
         end
         S_GRANTED: begin
            if (sensor_entry && sensor_exit) state_next = S_TAILGATE;
            else if (sensor_exit)            state_next = S_IDLE;
         end
         S_TAILGATE: begin
            if (code_done && code_match) state_next = S_GRANTED;
         end
`ifdef ATM_ROOM_LOCKOUT_EN
         S_LOCKOUT: begin
            if (phase_reg == PHASE_W'(LOCKOUT_CYCLES - 1)) state_next = S_IDLE;
         end
`endif
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      fail_next = fail_reg;
      if ((state_next == S_IDLE) || (state_next == S_GRANTED)) begin
         fail_next = '0;
      end else if (code_done && !code_match &&
                   ((state_reg == S_WAIT_CODE) || (state_reg == S_BAD_CODE))) begin
         fail_next = fail_inc;
      end
   end

   // Blink phase restarts lit on every state change.
   always_comb begin
      blink_next     = blink_reg;
      blink_cnt_next = blink_cnt_reg + 1'b1;
      if (state_change) begin
         blink_next     = 1'b1;
         blink_cnt_next = '0;
      end else if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
         blink_next     = ~blink_reg;
         blink_cnt_next = '0;
      end
   end

   always_comb begin
      red_next   = 1'b0;
      green_next = 1'b0;
      ready_next = 1'b0;
      disp1_next = 7'h7F;
      disp2_next = 7'h7F;
      case (state_next)
         S_WAIT_CODE: begin
            red_next   = 1'b1;
            ready_next = 1'b1;
            disp1_next = 7'b0000110;
            disp2_next = 7'b0101011;
         end
         S_BAD_CODE: begin
            red_next   = blink_next;
            ready_next = 1'b1;
            disp1_next = 7'b0000110;
            disp2_next = 7'b0000110;
         end
         S_GRANTED: begin
            green_next = blink_next;
            disp1_next = 7'b1000000;
            disp2_next = 7'b0001010;
         end
         S_TAILGATE: begin
            red_next   = blink_next;
            ready_next = 1'b1;
            disp1_next = 7'b0101011;
            disp2_next = 7'b0100011;
         end
`ifdef ATM_ROOM_LOCKOUT_EN
         S_LOCKOUT: begin
            red_next   = 1'b1;
            disp1_next = 7'b1000111;
            disp2_next = 7'b1000000;
         end
`endif
         default: begin
            red_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_reg       <= '0;
         dcnt_reg      <= '0;
         phase_reg     <= '0;
         blink_cnt_reg <= '0;
         blink_reg     <= 1'b0;
         fail_reg      <= '0;
         ready_reg     <= 1'b0;
         red_reg       <= 1'b0;
         green_reg     <= 1'b0;
         disp1_reg     <= 7'h7F;
         disp2_reg     <= 7'h7F;
      end else begin
         if (state_change || code_done) begin
            buf_reg  <= '0;
            dcnt_reg <= '0;
         end else if (accept) begin
            buf_reg  <= code_word[BUF_W-1:0];
            dcnt_reg <= dcnt_reg + 1'b1;
         end
         if (state_change || !phase_run) begin
            phase_reg <= '0;
         end else begin
            phase_reg <= phase_reg + 1'b1;
         end
         blink_cnt_reg <= blink_cnt_next;
         blink_reg     <= blink_next;
         fail_reg      <= fail_next;
         ready_reg     <= ready_next;
         red_reg       <= red_next;
         green_reg     <= green_next;
         disp1_reg     <= disp1_next;
         disp2_reg     <= disp2_next;
      end
   end

   assign digit_ready = ready_reg;
   assign red_light   = red_reg;
   assign green_light = green_reg;
   assign display_1   = disp1_reg;
   assign display_2   = disp2_reg;
   assign state_o     = state_reg;
   assign fail_count  = fail_reg;

endmodule

// File: tb/tb_atm_room_access_ctrl.sv
// Randomised scoreboard bench for atm_room_access_ctrl against a time-in-state reference model.
// Honours ATM_ROOM_LOCKOUT_EN the same way as the design.
module tb_atm_room_access_ctrl;

   localparam int         DIGITS         = 2;
   localparam int         DIGIT_W        = 2;
   localparam logic [3:0] PASSCODE       = 4'b0110;
   localparam int         ENTRY_TIMEOUT  = 32;
   localparam int         BLINK_DIV      = 2;
   localparam int         MAX_TRIES      = 3;
   localparam int         LOCKOUT_CYCLES = 16;
   localparam int         FW             = $clog2(MAX_TRIES + 1);

   localparam int ST_IDLE = 0, ST_WAIT = 1, ST_BAD = 2, ST_GRANT = 3, ST_TAIL = 4, ST_LOCK = 5;

`ifdef ATM_ROOM_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               sensor_entry = 1'b0, sensor_exit = 1'b0, digit_valid = 1'b0;
   logic [DIGIT_W-1:0] digit_in = '0;
   logic               digit_ready, green_light, red_light;
   logic [6:0]         display_1, display_2;
   logic [2:0]         state_o;
   logic [FW-1:0]      fail_count;

   atm_room_access_ctrl #(
      .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .PASSCODE(PASSCODE),
      .ENTRY_TIMEOUT(ENTRY_TIMEOUT), .BLINK_DIV(BLINK_DIV),
      .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sensor_entry(sensor_entry), .sensor_exit(sensor_exit),
      .digit_valid(digit_valid), .digit_in(digit_in), .digit_ready(digit_ready),
      .green_light(green_light), .red_light(red_light), .display_1(display_1),
      .display_2(display_2), .state_o(state_o), .fail_count(fail_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]    st;
      logic          red;
      logic          green;
      logic          rdy;
      logic [6:0]    d1;
      logic [6:0]    d2;
      logic [FW-1:0] fail;
   } snap_t;

   snap_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   // Reference model: state, cycles spent in it, entered digits, bad-code count.
   int                 m_state = ST_IDLE;
   int                 m_tis   = 0;
   int                 m_fail  = 0;
   logic [DIGIT_W-1:0] m_digits[$];

   function automatic snap_t model_out();
      snap_t s;
      logic  lit;
      lit    = ((m_tis / BLINK_DIV) % 2) == 0;
      s.st   = 3'(m_state);
      s.fail = FW'(m_fail);
      s.rdy  = (m_state == ST_WAIT) || (m_state == ST_BAD) || (m_state == ST_TAIL);
      s.red  = 1'b0;
      s.green = 1'b0;
      s.d1   = 7'h7F;
      s.d2   = 7'h7F;
      case (m_state)
         ST_WAIT:  begin s.red = 1'b1;  s.d1 = 7'b0000110; s.d2 = 7'b0101011; end
         ST_BAD:   begin s.red = lit;   s.d1 = 7'b0000110; s.d2 = 7'b0000110; end
         ST_GRANT: begin s.green = lit; s.d1 = 7'b1000000; s.d2 = 7'b0001010; end
         ST_TAIL:  begin s.red = lit;   s.d1 = 7'b0101011; s.d2 = 7'b0100011; end
         ST_LOCK:  begin s.red = 1'b1;  s.d1 = 7'b1000111; s.d2 = 7'b1000000; end
         default:  s.red = 1'b0;
      endcase
      return s;
   endfunction

   task automatic model_reset();
      m_state = ST_IDLE;
      m_tis   = 0;
      m_fail  = 0;
      m_digits.delete();
   endtask

   task automatic model_step(input logic en, input logic ex, input logic v,
                             input logic [DIGIT_W-1:0] d);
      int nxt;
      bit done;
      bit match;
      int code;
      nxt   = m_state;
      done  = 1'b0;
      match = 1'b0;
      if (v && ((m_state == ST_WAIT) || (m_state == ST_BAD) || (m_state == ST_TAIL))) begin
         m_digits.push_back(d);
         if (m_digits.size() == DIGITS) begin
            code = 0;
            foreach (m_digits[k]) code = (code << DIGIT_W) | int'(m_digits[k]);
            done  = 1'b1;
            match = (code == int'(PASSCODE));
            m_digits.delete();
         end
      end
      case (m_state)
         ST_IDLE: if (en) nxt = ST_WAIT;
         ST_WAIT, ST_BAD: begin
            if (done && match) begin
               nxt = ST_GRANT;
            end else if (done) begin
               m_fail = (m_fail < MAX_TRIES) ? m_fail + 1 : MAX_TRIES;
               nxt = (LOCK_EN && m_fail == MAX_TRIES) ? ST_LOCK : ST_BAD;
            end else if (m_state == ST_WAIT && m_tis == ENTRY_TIMEOUT - 1) begin
               nxt = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (en && ex) nxt = ST_TAIL;
            else if (ex)  nxt = ST_IDLE;
         end
         ST_TAIL: if (done && match) nxt = ST_GRANT;
         ST_LOCK: if (m_tis == LOCKOUT_CYCLES - 1) nxt = ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
      if (nxt == ST_IDLE || nxt == ST_GRANT) m_fail = 0;
      if (nxt != m_state) begin
         m_tis = 0;
         m_digits.delete();
      end else begin
         m_tis++;
      end
      m_state = nxt;
   endtask

   function automatic snap_t dut_snap();
      return {state_o, red_light, green_light, digit_ready, display_1, display_2, fail_count};
   endfunction

   task automatic compare(input string name, input snap_t e);
      snap_t a;
      a = dut_snap();
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s @%0t: got st=%0d red=%0b grn=%0b rdy=%0b d1=%07b d2=%07b fail=%0d, expected st=%0d red=%0b grn=%0b rdy=%0b d1=%07b d2=%07b fail=%0d",
                  name, $time, a.st, a.red, a.green, a.rdy, a.d1, a.d2, a.fail,
                  e.st, e.red, e.green, e.rdy, e.d1, e.d2, e.fail);
      end
   endtask

   // Monitor: the DUT presents a fresh output set after every edge; check it mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) compare("outputs", exp_q.pop_front());
   end

   task automatic cycle(input logic en, input logic ex, input logic v,
                        input logic [DIGIT_W-1:0] d);
      sensor_entry = en;
      sensor_exit  = ex;
      digit_valid  = v;
      digit_in     = d;
      model_step(en, ex, v, d);
      @(posedge clk);
      exp_q.push_back(model_out());
      $display("txn t=%0t en=%0b ex=%0b v=%0b d=%0d -> model st=%0d fail=%0d",
               $time, en, ex, v, d, m_state, m_fail);
      #1;
   endtask

   task automatic send(input int d);
      cycle(1'b0, 1'b0, 1'b1, DIGIT_W'(d));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      #1;
      reset_n      = 1'b0;
      sensor_entry = 1'b0;
      sensor_exit  = 1'b0;
      digit_valid  = 1'b0;
      model_reset();
      #1;
      compare("async_reset", model_out());
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(model_out());
         @(posedge clk);
         #1;
      end
      reset_n = 1'b1;
      $display("txn t=%0t reset released", $time);
   endtask

   initial begin
      int pick;
      int pos;
      logic [DIGIT_W-1:0] want;
      logic [3:0] pc;
      apply_reset(3);

      // valid entry, green blink, exit
      cycle(1'b1, 1'b0, 1'b0, '0);
      send(1); send(2);
      idle(6);
      cycle(1'b0, 1'b1, 1'b0, '0);

      // bad then good
      cycle(1'b1, 1'b0, 1'b0, '0);
      send(3); send(3);
      idle(3);
      send(1); send(2);
      cycle(1'b0, 1'b1, 1'b0, '0);

      // timeout with one digit entered
      cycle(1'b1, 1'b0, 1'b0, '0);
      send(1);
      idle(36);

      // tailgate and recovery
      cycle(1'b1, 1'b0, 1'b0, '0);
      send(1); send(2);
      cycle(1'b1, 1'b1, 1'b0, '0);
      idle(3);
      send(1); send(2);
      cycle(1'b0, 1'b1, 1'b0, '0);

      // repeated bad codes (lockout or saturating retries)
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin send(3); send(0); end
      idle(20);
      send(1); send(2);
      cycle(1'b0, 1'b1, 1'b0, '0);

      // asynchronous reset mid-code, then a fresh grant
      cycle(1'b1, 1'b0, 1'b0, '0);
      send(1);
      apply_reset(2);
      cycle(1'b1, 1'b0, 1'b0, '0);
      send(1); send(2);
      cycle(1'b0, 1'b1, 1'b0, '0);

      // randomised traffic, biased toward the correct next digit
      pc = PASSCODE;
      for (int i = 0; i < 3000; i++) begin
         pick = int'($urandom_range(0, 99));
         pos  = m_digits.size();
         want = DIGIT_W'(pc >> ((DIGITS - 1 - pos) * DIGIT_W));
         if ($urandom_range(0, 99) < 55) want = DIGIT_W'($urandom);
         cycle(pick < 20, (pick % 7) == 0, $urandom_range(0, 1) == 1, want);
      end
      idle(2);

      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
